// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU register-file types and constants
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_NUM    = 2 ** REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  // True when an address names the hardwired zero register.
  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// rtl/reg_file_2r1w_if.sv - register file write/read port bundle
interface reg_file_2r1w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              wr_zero_err;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b, wr_zero_err
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b, wr_zero_err
  );

endinterface

// File: rtl/reg_wr_decoder.sv
// rtl/reg_wr_decoder.sv - one-hot write-enable decode, register 0 never enabled
module reg_wr_decoder #(
  parameter int ADDR_W = 5
) (
  input  logic                 i_we,
  input  logic [ADDR_W-1:0]    i_waddr,
  output logic [2**ADDR_W-1:0] o_we_onehot
);

  always_comb begin
    o_we_onehot = '0;
    if (i_we && (i_waddr != '0)) begin
      o_we_onehot[i_waddr] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - 32x32 register file, 2 combinational reads, 1 write
// Optional same-cycle write-to-read forwarding under RF_WRITE_BYPASS_EN.
module reg_file_2r1w
  import cpu_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  reg_file_2r1w_if.slave      bus
);

  localparam int NUM = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NUM];
  logic              r_wr_zero_err;
  logic [NUM-1:0]    w_we_onehot;
  logic [DATA_W-1:0] w_rd_a_store;
  logic [DATA_W-1:0] w_rd_b_store;
  logic              w_zero_write;

  reg_wr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_wr_decoder (
    .i_we        (bus.we),
    .i_waddr     (bus.waddr),
    .o_we_onehot (w_we_onehot)
  );

  // Reset wins over a coincident write; entry 0 is only ever cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (w_we_onehot[i]) begin
          r_regs[i] <= bus.wdata;
        end
      end
    end
  end

  assign w_zero_write = bus.we && (bus.waddr == ADDR_W'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_zero_err <= 1'b0;
    end else begin
      r_wr_zero_err <= w_zero_write;
    end
  end

  assign w_rd_a_store = (bus.raddr_a == '0) ? '0 : r_regs[bus.raddr_a];
  assign w_rd_b_store = (bus.raddr_b == '0) ? '0 : r_regs[bus.raddr_b];

`ifdef RF_WRITE_BYPASS_EN
  logic w_fwd_a;
  logic w_fwd_b;

  assign w_fwd_a = bus.we && (bus.waddr != '0) && (bus.raddr_a == bus.waddr);
  assign w_fwd_b = bus.we && (bus.waddr != '0) && (bus.raddr_b == bus.waddr);

  assign bus.rdata_a = w_fwd_a ? bus.wdata : w_rd_a_store;
  assign bus.rdata_b = w_fwd_b ? bus.wdata : w_rd_b_store;
`else
  assign bus.rdata_a = w_rd_a_store;
  assign bus.rdata_b = w_rd_b_store;
`endif

  assign bus.wr_zero_err = r_wr_zero_err;

endmodule
